// File: rtl/circular_shift_pkg.sv
// Shared types for the iterative circular shifter: FSM states and rotate direction.
package circular_shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/rotate_pow2_stage.sv
// Fixed-distance combinational rotate by S in either direction.
module rotate_pow2_stage
  import circular_shift_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned S = 1
) (
  input  logic [N-1:0] a,
  input  dir_t         dir,
  output logic [N-1:0] res
);

  always_comb begin
    if (dir == DIR_LEFT) begin
      res = {a[N-1-S:0], a[N-1:N-S]};
    end else begin
      res = {a[S-1:0], a[N-1:S]};
    end
  end

endmodule

// File: rtl/circular_shift_sequencer.sv
// Sequences one power-of-two rotate stage per clock into a full variable rotator,
// with valid/ready handshakes on input and output.
module circular_shift_sequencer
  import circular_shift_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_amount,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam logic [W-1:0] KLast = W'(W - 1);

  state_t       state_q, state_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] amount_q, amount_d;
  dir_t         dir_q, dir_d;
  logic [N-1:0] work_q, work_d;
  logic [N-1:0] stage_res [W];

  for (genvar g = 0; g < W; g++) begin : g_stage
    rotate_pow2_stage #(
      .N(N),
      .S(1 << g)
    ) u_stage (
      .a   (work_q),
      .dir (dir_q),
      .res (stage_res[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      amount_q <= '0;
      dir_q    <= DIR_LEFT;
      work_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      amount_q <= amount_d;
      dir_q    <= dir_d;
      work_q   <= work_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    amount_d = amount_q;
    dir_d    = dir_q;
    work_d   = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d   = in_data;
          amount_d = in_amount;
          dir_d    = dir_t'(in_dir);
          k_d      = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // Every stage runs even when its amount bit is clear, keeping latency fixed at W.
        if (amount_q[k_q]) begin
          work_d = stage_res[k_q];
        end
        k_d = k_q + 1'b1;
        if (k_q == KLast) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? work_q : '0;
  assign busy      = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: doc/circular_shift_sequencer.md
# circular_shift_sequencer

Iterative variable-amount circular shifter with valid/ready handshakes on both sides. It accepts an N-bit word, a rotate amount and a direction. It then applies one power-of-two rotate stage per clock, selected by one bit of the amount, and presents the result until the consumer takes it. It is the control wrapper that sequences fixed-step rotate stages into a full rotator wherever a datapath needs runtime-selectable rotation without a full combinational barrel shifter.

## Interface
- `N`, default 8, data width; must be a power of two, ≥ 2.
- `W`, default `$clog2(N)`, width of the amount field; also the number of stages. Derived, never overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `in_data`  in  N  word to rotate.
- `in_amount`  in  W  rotate distance, 0..N-1.
- `in_dir`  in  1  0 = rotate left, 1 = rotate right.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  N  rotated word.
- `busy`  out  1  high in SHIFT or DONE.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, capture `in_data` into the working register, `in_amount` into the amount register, and `in_dir`.
  - Clear the stage counter k to 0 and go to SHIFT.
- **SHIFT**
  - Each cycle: if amount[k] = 1, the working register rotates by 2^k in the captured direction; otherwise it holds.
  - k increments each cycle.
  - After the stage with k = W-1, go to DONE.
  - All W stages always execute, including amount = 0, so latency is fixed.
- **DONE**
  - `out_valid` = 1 and `out_data` = working register.
  - On `out_ready`, go to IDLE.
  - `out_data` must stay stable while `out_valid && !out_ready`.
- Rotation semantics, e.g. N = 8, amount 3 (bits written 7..0):
  - left: ABCDEFGH → DEFGHABC;
  - right: ABCDEFGH → FGHABCDE.
  - Rotating by r is the composition of the stage rotations for the set bits of r. The result must equal `(x << r) | (x >> (N-r))` for left, and the mirrored expression for right, taken mod N.
- `in_ready` is low in SHIFT and DONE. `in_valid` in those states is ignored and consumes nothing.
- `in_ready` is combinational from state only, never from `in_valid`. `out_valid` is combinational from state only, never from `out_ready`.
- No output is dropped or duplicated. Exactly one result per accepted request.

## Timing
- **Reset** (`rst_n` low at a rising edge):
  - state becomes IDLE, k = 0, working register = 0;
  - `out_valid` = 0, `out_data` = 0, `busy` = 0;
  - `in_ready` is forced 0 while `rst_n` is low and is 1 from the first cycle after release.
- **Reset mid-operation** (SHIFT or DONE): the request is abandoned, no `out_valid` pulse follows, and the next cycle is IDLE.
- **Latency:** with the handshake at edge e0, SHIFT occupies edges e1..eW. `out_valid` is first high in the cycle after edge eW, i.e. W cycles after acceptance. For N = 8 that is 3 cycles.
- **Throughput:** at most one request per W+2 cycles (W SHIFT, ≥1 DONE, 1 IDLE).
- **DONE with `out_ready` already high:** DONE lasts exactly one cycle.
- **`out_ready` during IDLE or SHIFT:** has no effect.
- **Amount width:** no modulo is needed because `in_amount` cannot exceed N-1.

## Structure
- Package `circular_shift_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t`;
  - `typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t`.
- Sub-module `rotate_pow2_stage`:
  - parameters N and S; ports `a`, `dir`, `res`;
  - purely combinational; rotates `a` by S in either direction using slice concatenation.
- Top level:
  - instantiates one `rotate_pow2_stage` per stage in a generate loop, with S = 2^k;
  - the counter selects which stage output is written back;
  - the FSM is in the top module.

## Test plan
- **Left rotate:** N = 8; `in_data` 8'b10110101, amount 3, left → `out_data` 8'b10101101, `out_valid` first high exactly 3 cycles after the accept edge.
- **Right rotate:** 8'b10110101, amount 3, right → 8'b10110110. Then 8'b00000001, amount 7, left → 8'b10000000.
- **Zero amount:** 8'b01100110, amount 0, either direction → 8'b01100110 with the same 3-cycle latency.
- **Backpressure:** hold `out_ready` low for 5 cycles in DONE → `out_valid` and `out_data` stable throughout; raise `out_ready` → IDLE next cycle and `in_ready` = 1.
- **Busy ignores input:** toggle `in_valid` with new data during SHIFT and DONE → ignored; exactly one result, the first request's.
- **Reset mid-SHIFT:** drop `rst_n` during SHIFT → next cycle `out_valid` = 0, `out_data` = 0, IDLE; a following request 8'b11100000, amount 3, left → 8'b00000111 correctly.
